// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam logic [3:0]  OP_HLT            = 4'hF;
    localparam logic [2:0]  BRANCH_PREFIX     = 3'b110;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h7000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_RUN      = 2'd0;
    localparam fetch_state_t ST_WAIT_MEM = 2'd1;
    localparam fetch_state_t ST_HALT     = 2'd2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with prioritised next-PC selection:
// redirect > stall > halt freeze > sequential advance.
module fetch_pc_reg #(
    parameter int unsigned         PC_W     = 16,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            stall,
    input  logic            hold,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (stall || hold) begin
            pc_d = pc_q;
        end else if (advance) begin
            pc_d = pc_q + PC_W'(2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC ownership, imem handshake, bubble insertion, redirect and HLT freeze.
// Define FETCH_PERF_CNT_EN to add the saturating miss_cycles counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]     NOP_INSTR = NOP_INSTR_DEFAULT
`ifdef FETCH_PERF_CNT_EN
    , parameter int unsigned   CNT_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_rdata,
    input  logic             imem_valid,
    output logic [PC_W-1:0]  pc_out,
    output logic [PC_W-1:0]  incremented_pc,
    output logic [15:0]      instr_out,
    output logic             fetch_valid,
    output logic             branch_instr,
    output logic             flush_out,
    output logic             halted
`ifdef FETCH_PERF_CNT_EN
    , output logic [CNT_W-1:0] miss_cycles
`endif
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic [PC_W-1:0] pc;
    logic            active;
    logic            present;
    logic            is_hlt;
    logic            outstanding;

    // Gating with rst_n keeps the request and outputs quiet while reset is held.
    assign active      = rst_n && (state_q != ST_HALT);
    assign present     = active && imem_valid && !((state_q == ST_WAIT_MEM) && drop_q);
    assign is_hlt      = present && (imem_rdata[15:12] == OP_HLT) && !branch_taken && !stall;
    assign outstanding = active && !imem_valid;

    assign imem_req       = active;
    assign imem_addr      = pc;
    assign pc_out         = pc;
    assign incremented_pc = pc + PC_W'(2);
    assign fetch_valid    = present;
    assign instr_out      = present ? imem_rdata : NOP_INSTR;
    assign branch_instr   = present && (imem_rdata[15:13] == BRANCH_PREFIX);
    assign flush_out      = branch_taken;
    assign halted         = (state_q == ST_HALT);

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (branch_taken) begin
            // A request still in flight returns the old word; mark it for discard.
            state_d = outstanding ? ST_WAIT_MEM : ST_RUN;
            drop_d  = outstanding;
        end else if (is_hlt) begin
            state_d = ST_HALT;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!imem_valid) state_d = ST_WAIT_MEM;
                end
                ST_WAIT_MEM: begin
                    if (imem_valid) begin
                        state_d = ST_RUN;
                        drop_d  = 1'b0;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: begin
                    state_d = ST_RUN;
                    drop_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .hold          (is_hlt),
        .advance       (present),
        .pc            (pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if ((state_q == ST_WAIT_MEM) && (miss_q != {CNT_W{1'b1}})) begin
            miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign miss_cycles = miss_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected fetches are queued as stimulus is
// driven and compared when the stage presents a valid instruction.
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] inc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] pc_out;
    logic [15:0] incremented_pc;
    logic [15:0] instr_out;
    logic        fetch_valid;
    logic        branch_instr;
    logic        flush_out;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_cycles;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .pc_out         (pc_out),
        .incremented_pc (incremented_pc),
        .instr_out      (instr_out),
        .fetch_valid    (fetch_valid),
        .branch_instr   (branch_instr),
        .flush_out      (flush_out),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        , .miss_cycles  (miss_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational outputs, then advance a clock.
    task automatic step(input logic v, input logic [15:0] rd, input logic st, input logic br,
                        input logic [15:0] tgt, input logic exp_fv, input logic [15:0] exp_addr);
        exp_t e;
        imem_valid    = v;
        imem_rdata    = rd;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (exp_fv) sb.push_back('{addr: exp_addr, instr: rd, inc: exp_addr + 16'd2});
        #2;
        check_val("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
        check_val("flush_out", 32'(flush_out), 32'(br));
        check_val("branch_instr", 32'(branch_instr), 32'(exp_fv && (rd[15:13] == 3'b110)));
        if (fetch_valid) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_val("imem_addr", 32'(imem_addr), 32'(e.addr));
                check_val("instr_out", 32'(instr_out), 32'(e.instr));
                check_val("incremented_pc", 32'(incremented_pc), 32'(e.inc));
            end
        end else begin
            check_val("bubble", 32'(instr_out), 32'h7000);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_valid    = 1'b0;
        imem_rdata    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_fv", 32'(fetch_valid), 32'd0);
        check_val("rst_instr", 32'(instr_out), 32'h7000);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_pc", 32'(pc_out), 32'h0000);
`ifdef FETCH_PERF_CNT_EN
        check_val("rst_miss", 32'(miss_cycles), 32'd0);
`endif
        rst_n = 1'b1;

        // Sequential fetch with zero-wait memory
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'(2 * i));
        end
        check_val("seq_pc", 32'(pc_out), 32'h0008);

        // Stall holds the PC; branch overrides stall
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0008);
            check_val("stall_pc", 32'(pc_out), 32'h0008);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0008);
        step(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h000A);
        check_val("br_stall_pc", 32'(pc_out), 32'h0010);

        // Three wait cycles at 0x0010
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            check_val("miss_addr", 32'(imem_addr), 32'h0010);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0010);
`ifdef FETCH_PERF_CNT_EN
        check_val("miss_cycles", 32'(miss_cycles), 32'd3);
`endif

        // Branch mid-miss: the returning word is dropped
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check_val("drop_pc", 32'(pc_out), 32'h0100);
        step(1'b1, 16'hC123, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0100);

        // HLT freeze and branch release
        step(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0020, 1'b1, 16'h0102);
        step(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0020);
        check_val("hlt_halted", 32'(halted), 32'd1);
        check_val("hlt_req", 32'(imem_req), 32'd0);
        check_val("hlt_pc", 32'(pc_out), 32'h0020);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            check_val("hlt_hold_pc", 32'(pc_out), 32'h0020);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0);
        check_val("unhalt", 32'(halted), 32'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0040);

        // PC wrap at the top of the address space
        step(1'b1, 16'h1234, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h0042);
        check_val("wrap_inc", 32'(incremented_pc), 32'h0000);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0000);

        // Asynchronous reset in the middle of a miss
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        check_val("pre_rst_pc", 32'(pc_out), 32'h0002);
        imem_valid = 1'b1;
        imem_rdata = 16'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_pc", 32'(pc_out), 32'h0000);
        check_val("arst_fv", 32'(fetch_valid), 32'd0);
        check_val("arst_req", 32'(imem_req), 32'd0);
        check_val("arst_instr", 32'(instr_out), 32'h7000);
`ifdef FETCH_PERF_CNT_EN
        check_val("arst_miss", 32'(miss_cycles), 32'd0);
`endif
        check_val("sb_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
